// File: rtl/fx3_wr_pkg.sv
// Shared types and defaults for the FX3 slave-FIFO burst writer.
package fx3_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BURST  = 3'd1,
    ST_TAIL   = 3'd2,
    ST_PKTEND = 3'd3,
    ST_GAP    = 3'd4
  } wr_state_e;

  // Cycles from a FIFO read request to the matching FX3 write strobe
  localparam int RD_LAT        = 2;
  localparam int DEF_BURST_LEN = 256;
  localparam int DEF_BUF_WORDS = 512;
  // Width of the shared burst / tail / gap down-counter
  localparam int CNT_W         = 16;

endpackage

// File: rtl/fx3_burst_writer.sv
// Drains the camera data FIFO into the FX3 GPIF-II slave FIFO in fixed bursts,
// gated by the FX3 watermark flag, and closes partial DMA buffers with PKTEND
// when an end-of-frame flush is requested.
module fx3_burst_writer
  import fx3_wr_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int BUF_WORDS = DEF_BUF_WORDS,
  parameter int FLAG_LAT  = 3,
  parameter int ZLP_EN    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fifo_rdreq,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_rdempty,
  input  logic [ADDR_W-1:0] fifo_rdusedw,
  input  logic              flush_req,
  input  logic              fx3_flaga,
  output logic [DATA_W-1:0] fx3_data,
  output logic              fx3_slwr_n,
  output logic              fx3_pktend_n,
  output logic              busy
);

  localparam int BUF_W = $clog2(BUF_WORDS);

  wr_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flush_mode_q, flush_mode_d;
  logic               flush_pend_q, flush_pend_d;
  logic [BUF_W-1:0]   buf_cnt_q, buf_cnt_d;
  logic               rd_vld_q, rd_vld_d;
  logic               rdreq_q, rdreq_d;
  logic               slwr_n_q, slwr_n_d;
  logic               pktend_n_q, pktend_n_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               busy_q, busy_d;

  logic               avail_full_s;
  logic [CNT_W-1:0]   avail_s;

  // rdusedw wraps to 0 when the FIFO is completely full, so a zero level with
  // a non-empty FIFO is taken as at least one full burst available.
  always_comb begin
    avail_full_s = ((fifo_rdusedw == ADDR_W'(0)) && !fifo_rdempty) ||
                   (CNT_W'(fifo_rdusedw) >= CNT_W'(BURST_LEN));
    if ((fifo_rdusedw == ADDR_W'(0)) && !fifo_rdempty) begin
      avail_s = CNT_W'(BURST_LEN);
    end else begin
      avail_s = CNT_W'(fifo_rdusedw);
    end
  end

  // Next-state logic: burst sequencing, read-valid pipe, buffer fill count and flush tracking
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_mode_d = flush_mode_q;
    flush_pend_d = flush_pend_q;
    rdreq_d      = 1'b0;
    pktend_n_d   = 1'b1;
    // Non-showahead FIFO: q is valid the cycle after rdreq, and the word is
    // presented on the bus with its strobe one cycle later still.
    rd_vld_d     = rdreq_q;
    slwr_n_d     = ~rd_vld_q;
    if (rd_vld_q) begin
      data_d = fifo_q;
    end else begin
      data_d = data_q;
    end
    // Count every write strobe actually issued; natural wrap mirrors the FX3 auto-commit
    if (!slwr_n_q) begin
      buf_cnt_d = buf_cnt_q + BUF_W'(1);
    end else begin
      buf_cnt_d = buf_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fx3_flaga && avail_full_s) begin
          state_d      = ST_BURST;
          cnt_d        = CNT_W'(BURST_LEN - 1);
          flush_mode_d = 1'b0;
          rdreq_d      = 1'b1;
        end else if (fx3_flaga && flush_pend_q && !fifo_rdempty) begin
          state_d      = ST_BURST;
          cnt_d        = avail_s - CNT_W'(1);
          flush_mode_d = 1'b1;
          rdreq_d      = 1'b1;
        end else if (fx3_flaga && flush_pend_q && fifo_rdempty && (buf_cnt_q != BUF_W'(0))) begin
          state_d    = ST_PKTEND;
          pktend_n_d = 1'b0;
        end else if (flush_pend_q && fifo_rdempty && (buf_cnt_q == BUF_W'(0))) begin
          if (ZLP_EN != 0) begin
            if (fx3_flaga) begin
              state_d    = ST_PKTEND;
              pktend_n_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            // Nothing pending and the buffer is already committed: drop the flush
            flush_pend_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = ST_TAIL;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          rdreq_d = 1'b1;
        end
      end
      ST_TAIL: begin
        if (cnt_q != CNT_W'(0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (flush_mode_q) begin
          // PKTEND lands on the cycle right after the last write strobe
          state_d    = ST_PKTEND;
          pktend_n_d = 1'b0;
        end else begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(FLAG_LAT - 1);
        end
      end
      ST_PKTEND: begin
        buf_cnt_d    = BUF_W'(0);
        flush_pend_d = 1'b0;
        flush_mode_d = 1'b0;
        state_d      = ST_GAP;
        cnt_d        = CNT_W'(FLAG_LAT - 1);
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase

    // A new end-of-frame pulse is never lost, even on the cycle a flush completes
    flush_pend_d = flush_pend_d | flush_req;
    busy_d       = (state_d != ST_IDLE) || flush_pend_d;
  end

  // State and registered outputs; reset forces the pins idle at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_W'(0);
      flush_mode_q <= 1'b0;
      flush_pend_q <= 1'b0;
      buf_cnt_q    <= BUF_W'(0);
      rd_vld_q     <= 1'b0;
      rdreq_q      <= 1'b0;
      slwr_n_q     <= 1'b1;
      pktend_n_q   <= 1'b1;
      data_q       <= DATA_W'(0);
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_mode_q <= flush_mode_d;
      flush_pend_q <= flush_pend_d;
      buf_cnt_q    <= buf_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rdreq_q      <= rdreq_d;
      slwr_n_q     <= slwr_n_d;
      pktend_n_q   <= pktend_n_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_rdreq   = rdreq_q;
  assign fx3_slwr_n   = slwr_n_q;
  assign fx3_pktend_n = pktend_n_q;
  assign fx3_data     = data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fx3_burst_writer.sv
// Directed bench for fx3_burst_writer: behavioural non-showahead FIFO, bus
// monitor, table of end-to-end transfers and hand-written corner sequences.
module tb_fx3_burst_writer;

  localparam int LOGN = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (ZLP disabled)
  logic        fifo_rdreq;
  logic [15:0] fifo_q;
  logic        fifo_rdempty;
  logic [9:0]  fifo_rdusedw;
  logic        flush_req = 1'b0;
  logic        fx3_flaga = 1'b1;
  logic [15:0] fx3_data;
  logic        fx3_slwr_n, fx3_pktend_n, busy;

  fx3_burst_writer #(.DATA_W(16), .ADDR_W(10), .BURST_LEN(256), .BUF_WORDS(512),
                     .FLAG_LAT(3), .ZLP_EN(0)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q),
    .fifo_rdempty(fifo_rdempty), .fifo_rdusedw(fifo_rdusedw), .flush_req(flush_req),
    .fx3_flaga(fx3_flaga), .fx3_data(fx3_data), .fx3_slwr_n(fx3_slwr_n),
    .fx3_pktend_n(fx3_pktend_n), .busy(busy));

  // Second DUT with ZLP enabled, permanently empty FIFO
  logic        z_flush = 1'b0;
  logic        z_rdreq, z_slwr_n, z_pktend_n, z_busy;
  logic [15:0] z_data;

  fx3_burst_writer #(.DATA_W(16), .ADDR_W(10), .BURST_LEN(256), .BUF_WORDS(512),
                     .FLAG_LAT(3), .ZLP_EN(1)) dut_zlp (
    .clk(clk), .rst_n(rst_n), .fifo_rdreq(z_rdreq), .fifo_q(16'h0000),
    .fifo_rdempty(1'b1), .fifo_rdusedw(10'd0), .flush_req(z_flush),
    .fx3_flaga(1'b1), .fx3_data(z_data), .fx3_slwr_n(z_slwr_n),
    .fx3_pktend_n(z_pktend_n), .busy(z_busy));

  // Behavioural 1024-deep non-showahead FIFO with bulk preload
  logic [15:0] mem [0:1023];
  logic [9:0]  rp_r, wp_r;
  logic [10:0] cnt_r;
  logic [15:0] q_r;
  logic        load_req = 1'b0;
  int          load_n = 0;
  logic [15:0] load_base = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_r  <= 10'd0;
      wp_r  <= 10'd0;
      cnt_r <= 11'd0;
      q_r   <= 16'h0000;
    end else begin
      if (fifo_rdreq && cnt_r != 11'd0) begin
        q_r  <= mem[rp_r];
        rp_r <= rp_r + 10'd1;
      end
      if (load_req) begin
        for (int i = 0; i < 1024; i++)
          if (i < load_n) mem[wp_r + 10'(i)] <= load_base + 16'(i);
        wp_r <= wp_r + 10'(load_n);
      end
      cnt_r <= cnt_r + (load_req ? 11'(load_n) : 11'd0)
                     - ((fifo_rdreq && cnt_r != 11'd0) ? 11'd1 : 11'd0);
    end
  end

  assign fifo_q       = q_r;
  assign fifo_rdempty = (cnt_r == 11'd0);
  assign fifo_rdusedw = cnt_r[9:0];

  // Bus monitor, sampled mid-cycle
  int          beats_r = 0, runs_r = 0, pkt_r = 0, pkt_adj_r = 0, viol_r = 0;
  int          cyc_r = 0, rd_start_r = 0, last_lat_r = -1;
  logic        prev_wr_r = 1'b0, prev_rd_r = 1'b0;
  logic [15:0] beat_log [0:LOGN-1];
  int          z_pkt_r = 0, z_wr_r = 0, z_rd_r = 0;

  always @(negedge clk) begin
    cyc_r     <= cyc_r + 1;
    prev_wr_r <= !fx3_slwr_n;
    prev_rd_r <= fifo_rdreq;
    if (!fx3_slwr_n) begin
      beat_log[beats_r % LOGN] <= fx3_data;
      beats_r <= beats_r + 1;
      if (!prev_wr_r) begin
        runs_r     <= runs_r + 1;
        last_lat_r <= cyc_r - rd_start_r;
      end
    end
    if (fifo_rdreq && !prev_rd_r) rd_start_r <= cyc_r;
    if (!fx3_pktend_n) begin
      pkt_r <= pkt_r + 1;
      if (prev_wr_r) pkt_adj_r <= pkt_adj_r + 1;
    end
    if ((fifo_rdreq && fifo_rdempty) || (!fx3_pktend_n && !fx3_slwr_n)) viol_r <= viol_r + 1;
    if (!z_pktend_n) z_pkt_r <= z_pkt_r + 1;
    if (!z_slwr_n)   z_wr_r  <= z_wr_r + 1;
    if (z_rdreq)     z_rd_r  <= z_rd_r + 1;
  end

  int          total = 0, bad = 0;
  logic [15:0] exp_q [$];

  typedef struct {
    int          load_n;
    logic [15:0] base;
    logic        flush;
    int          exp_beats;
    int          exp_pkt;
    int          exp_runs;
    int          exp_remain;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int n, input logic [15:0] base);
    @(negedge clk);
    load_n    = n;
    load_base = base;
    load_req  = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(base + 16'(i));
    @(negedge clk);
    load_req  = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
  endtask

  // Wait until the writer has been quiet for 8 cycles, bounded
  task automatic wait_done(input string name);
    int quiet;
    int k;
    quiet = 0;
    for (k = 0; k < 6000 && quiet < 8; k++) begin
      @(negedge clk);
      if (!busy && !fifo_rdreq && fx3_slwr_n) quiet++;
      else quiet = 0;
    end
    check({name, "_done"}, (quiet >= 8) ? 1 : 0, 1);
  endtask

  // Compare every beat logged since b0 against the words loaded, in order
  task automatic check_data(input string name, input int b0);
    int err;
    logic [15:0] w;
    err = 0;
    for (int i = b0; i < beats_r; i++) begin
      if (exp_q.size() == 0) err++;
      else begin
        w = exp_q.pop_front();
        if (beat_log[i % LOGN] != w) err++;
      end
    end
    check({name, "_data_errs"}, err, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rdreq"},  int'(fifo_rdreq),   0);
    check({name, "_slwr_n"}, int'(fx3_slwr_n),   1);
    check({name, "_pktend"}, int'(fx3_pktend_n), 1);
    check({name, "_data"},   int'(fx3_data),     0);
    check({name, "_busy"},   int'(busy),         0);
  endtask

  initial begin
    int b0, p0, r0, a0, rd0, k;

    //         load  base      fl    beats pkt runs remain
    vecs[0] = '{256,  16'h0000, 1'b0, 256,  0,  1,   0};   // single full burst
    vecs[1] = '{100,  16'h1000, 1'b1, 100,  1,  1,   0};   // partial + PKTEND
    vecs[2] = '{0,    16'h0000, 1'b1, 0,    0,  0,   0};   // flush, empty, buf_cnt 0
    vecs[3] = '{512,  16'h2000, 1'b0, 512,  0,  2,   0};   // fills one DMA buffer
    vecs[4] = '{0,    16'h0000, 1'b1, 0,    0,  0,   0};   // wrapped: no PKTEND
    vecs[5] = '{1024, 16'h3000, 1'b0, 1024, 0,  4,   0};   // full FIFO, rdusedw=0
    vecs[6] = '{10,   16'h4000, 1'b0, 0,    0,  0,   10};  // below burst, wait
    vecs[7] = '{0,    16'h0000, 1'b1, 10,   1,  1,   0};   // flush leftovers
    vecs[8] = '{300,  16'h4100, 1'b1, 300,  1,  2,   0};   // burst then flush tail

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_zlp_busy", int'(z_busy), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      b0 = beats_r; p0 = pkt_r; r0 = runs_r; a0 = pkt_adj_r;
      if (vecs[v].load_n > 0) load(vecs[v].load_n, vecs[v].base);
      if (vecs[v].flush) pulse_flush();
      wait_done($sformatf("v%0d", v));
      check($sformatf("v%0d_beats", v),  beats_r - b0,   vecs[v].exp_beats);
      check($sformatf("v%0d_pktend", v), pkt_r - p0,     vecs[v].exp_pkt);
      check($sformatf("v%0d_pkt_adj", v), pkt_adj_r - a0, vecs[v].exp_pkt);
      check($sformatf("v%0d_runs", v),   runs_r - r0,    vecs[v].exp_runs);
      check($sformatf("v%0d_remain", v), int'(cnt_r),    vecs[v].exp_remain);
      check($sformatf("v%0d_busy", v),   int'(busy),     0);
      check_data($sformatf("v%0d", v), b0);
      if (v == 0) check("v0_rdreq_to_beat_lat", last_lat_r, 2);
    end

    // Watermark gating: nothing is read while flaga is low
    fx3_flaga = 1'b0;
    b0 = beats_r; p0 = pkt_r; rd0 = rdreq_r_snapshot();
    load(300, 16'h7000);
    repeat (20) @(negedge clk);
    check("flaga_low_rdreqs", rdreq_r_snapshot() - rd0, 0);
    check("flaga_low_busy", int'(busy), 0);
    fx3_flaga = 1'b1;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (fifo_rdreq) break;
    end
    check("flaga_rise_lat_ok", (k <= 2) ? 1 : 0, 1);
    wait_done("flaga");
    check("flaga_beats", beats_r - b0, 256);
    check("flaga_remain", int'(cnt_r), 44);
    check("flaga_pktend", pkt_r - p0, 0);
    pulse_flush();
    wait_done("flaga_flush");
    check("flaga_flush_beats", beats_r - b0, 300);
    check("flaga_flush_pktend", pkt_r - p0, 1);
    check_data("flaga", b0);

    // Zero-length packet on the ZLP-enabled instance
    check("zlp_idle_pkt", z_pkt_r, 0);
    @(negedge clk);
    z_flush = 1'b1;
    @(negedge clk);
    z_flush = 1'b0;
    repeat (15) @(negedge clk);
    check("zlp_pktend", z_pkt_r, 1);
    check("zlp_writes", z_wr_r, 0);
    check("zlp_rdreqs", z_rd_r, 0);
    check("zlp_busy", int'(z_busy), 0);

    // Reset asserted mid-burst after 50 beats
    b0 = beats_r;
    load(256, 16'h5000);
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (beats_r - b0 >= 50) break;
    end
    check("midrst_beats_before", beats_r - b0, 50);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    check("midrst_beats_after", beats_r - b0, 50);
    check_data("midrst", b0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    b0 = beats_r; r0 = runs_r;
    load(256, 16'h6000);
    wait_done("postrst");
    check("postrst_beats", beats_r - b0, 256);
    check("postrst_runs", runs_r - r0, 1);
    check_data("postrst", b0);

    check("protocol_violations", viol_r, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Running count of cycles with fifo_rdreq high
  int rdreq_cnt_r = 0;
  always @(negedge clk) begin
    if (fifo_rdreq) rdreq_cnt_r <= rdreq_cnt_r + 1;
  end

  function automatic int rdreq_r_snapshot();
    return rdreq_cnt_r;
  endfunction

endmodule
